// File: rtl/new_feature_writer_if.sv
// Vector handshake and BRAM write-port bundle for new_feature_writer.
// slave: the writer's view; master: the upstream producer / BRAM side.
interface new_feature_writer_if #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned IN_DATA_WIDTH   = 20,
  parameter int unsigned NUM_FEATURE_OUT = 16,
  parameter int unsigned NUM_SUBGRAPHS   = 2708
);
  localparam int unsigned NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT;
  localparam int unsigned NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH);

  logic                                      feat_vec_valid;
  logic                                      feat_vec_ready;
  logic [IN_DATA_WIDTH*NUM_FEATURE_OUT-1:0]  feat_vec_data;
  logic                                      feat_bram_ena;
  logic                                      feat_bram_wea;
  logic [NEW_FEATURE_ADDR_W-1:0]             feat_bram_addra;
  logic [DATA_WIDTH-1:0]                     feat_bram_din;

  modport slave (
    input  feat_vec_valid, feat_vec_data,
    output feat_vec_ready, feat_bram_ena, feat_bram_wea, feat_bram_addra, feat_bram_din
  );

  modport master (
    output feat_vec_valid, feat_vec_data,
    input  feat_vec_ready, feat_bram_ena, feat_bram_wea, feat_bram_addra, feat_bram_din
  );
endinterface

// File: rtl/new_feature_writer.sv
// GAT output stage: saturates each aggregated vector and writes it to BRAM one word per cycle.
// Define NEW_FEATURE_WRITER_RELU_EN to clamp negative elements to zero before saturation.
module new_feature_writer #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned IN_DATA_WIDTH   = 20,
  parameter int unsigned NUM_FEATURE_OUT = 16,
  parameter int unsigned NUM_SUBGRAPHS   = 2708,
  localparam int unsigned SG_CNT_W       = $clog2(NUM_SUBGRAPHS + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  new_feature_writer_if.slave         bus,
  output logic [SG_CNT_W-1:0]         subgraph_cnt,
  output logic                        done,
  output logic                        overflow_err
);

  localparam int unsigned NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT;
  localparam int unsigned NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH);
  localparam int unsigned ELEM_W             = (NUM_FEATURE_OUT > 1) ? $clog2(NUM_FEATURE_OUT) : 1;
  localparam logic signed [IN_DATA_WIDTH-1:0] SAT_MAX = IN_DATA_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [IN_DATA_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_VEC, S_WRITE, S_DONE} state_e;

  state_e                                           state_q;
  logic [NEW_FEATURE_ADDR_W-1:0]                    addr_q;
  logic [ELEM_W-1:0]                                elem_q;
  logic [SG_CNT_W-1:0]                              sg_cnt_q;
  logic                                             ovf_q;
  logic [NUM_FEATURE_OUT-1:0][IN_DATA_WIDTH-1:0]    vec_q;

  logic                             last_elem_c;
  logic                             final_sg_c;
  logic                             ready_c;
  logic                             accept_c;
  logic signed [IN_DATA_WIDTH-1:0]  elem_val_c;
  logic [DATA_WIDTH-1:0]            din_c;

  // Handshake decode; ready depends only on registered state so there is no input-to-output path
  always_comb begin
    last_elem_c = (elem_q == ELEM_W'(NUM_FEATURE_OUT - 1));
    final_sg_c  = (sg_cnt_q == SG_CNT_W'(NUM_SUBGRAPHS - 1));
    ready_c     = (state_q == S_WAIT_VEC) ||
                  ((state_q == S_WRITE) && last_elem_c && !final_sg_c);
    accept_c    = ready_c && bus.feat_vec_valid;
  end

  // Signed saturation of the current element
  always_comb begin
    elem_val_c = vec_q[elem_q];
    din_c      = elem_val_c[DATA_WIDTH-1:0];
    if (elem_val_c > SAT_MAX) begin
      din_c = SAT_MAX[DATA_WIDTH-1:0];
    end else if (elem_val_c < SAT_MIN) begin
      din_c = SAT_MIN[DATA_WIDTH-1:0];
    end
`ifdef NEW_FEATURE_WRITER_RELU_EN
    if (elem_val_c[IN_DATA_WIDTH-1]) begin
      din_c = '0;
    end
`endif
  end

  // start has priority over every state and any coincident handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      elem_q   <= '0;
      sg_cnt_q <= '0;
      ovf_q    <= 1'b0;
      vec_q    <= '0;
    end else if (start) begin
      state_q  <= S_WAIT_VEC;
      addr_q   <= '0;
      elem_q   <= '0;
      sg_cnt_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_WAIT_VEC: begin
          if (accept_c) begin
            vec_q   <= bus.feat_vec_data;
            elem_q  <= '0;
            state_q <= S_WRITE;
          end
        end
        S_WRITE: begin
          // Hold at the last word so the address never leaves the BRAM range
          if (addr_q != NEW_FEATURE_ADDR_W'(NEW_FEATURE_DEPTH - 1)) begin
            addr_q <= addr_q + 1'b1;
          end
          if (last_elem_c) begin
            sg_cnt_q <= sg_cnt_q + 1'b1;
            if (accept_c) begin
              vec_q  <= bus.feat_vec_data;
              elem_q <= '0;
            end else begin
              state_q <= final_sg_c ? S_DONE : S_WAIT_VEC;
            end
          end else begin
            elem_q <= elem_q + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.feat_vec_valid) begin
            ovf_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.feat_vec_ready  = ready_c;
  assign bus.feat_bram_ena   = (state_q == S_WRITE);
  assign bus.feat_bram_wea   = (state_q == S_WRITE);
  assign bus.feat_bram_addra = addr_q;
  assign bus.feat_bram_din   = din_c;
  assign subgraph_cnt        = sg_cnt_q;
  assign done                = (state_q == S_DONE);
  assign overflow_err        = ovf_q;

endmodule

// File: tb/tb_new_feature_writer.sv
// Self-checking bench for new_feature_writer: table-driven vectors plus a write scoreboard.
module tb_new_feature_writer;
  localparam int DW    = 8;
  localparam int IW    = 20;
  localparam int NFO   = 4;
  localparam int NSG   = 3;
  localparam int DEPTH = NSG * NFO;
  localparam int SGW   = $clog2(NSG + 1);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [SGW-1:0] subgraph_cnt;
  logic           done;
  logic           overflow_err;

  always #5 clk = ~clk;

  new_feature_writer_if #(
    .DATA_WIDTH(DW), .IN_DATA_WIDTH(IW), .NUM_FEATURE_OUT(NFO), .NUM_SUBGRAPHS(NSG)
  ) bus_if ();

  new_feature_writer #(
    .DATA_WIDTH(DW), .IN_DATA_WIDTH(IW), .NUM_FEATURE_OUT(NFO), .NUM_SUBGRAPHS(NSG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus_if.slave),
    .subgraph_cnt(subgraph_cnt), .done(done), .overflow_err(overflow_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct { int addr; int din; } wr_t;
  typedef struct { int e[4]; int sat[4]; int relu[4]; } vec_t;

  wr_t  exp_q[$];
  wr_t  w;
  int   exp_addr = 0;
  vec_t tbl[4];

  int   cyc = 0;
  int   first_wr_cyc = -1;
  int   last_wr_cyc = -1;
  int   done_cyc = -1;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc++;

  // Write monitor: every BRAM write must match the head of the scoreboard
  always @(negedge clk) begin
    if (bus_if.feat_bram_ena) begin
      if (int'(bus_if.feat_bram_addra) == 0) first_wr_cyc = cyc;
      if (int'(bus_if.feat_bram_addra) == DEPTH - 1) last_wr_cyc = cyc;
      check("wea", int'(bus_if.feat_bram_wea), 1);
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", int'(bus_if.feat_bram_addra), -1);
      end else begin
        w = exp_q.pop_front();
        check("addr", int'(bus_if.feat_bram_addra), w.addr);
        check("din", int'($signed(bus_if.feat_bram_din)), w.din);
      end
    end
    if (done && !prev_done) done_cyc = cyc;
    prev_done = done;
  end

  function automatic logic [IW*NFO-1:0] pack(input vec_t v);
    logic [IW*NFO-1:0] d;
    d = '0;
    for (int i = 0; i < NFO; i++) d[i*IW +: IW] = IW'(v.e[i]);
    return d;
  endfunction

  // Present one vector, wait for acceptance, and queue its expected words
  task automatic send_vec(input int idx);
    int n;
    n = 0;
    bus_if.feat_vec_data  = pack(tbl[idx]);
    bus_if.feat_vec_valid = 1'b1;
    while (!bus_if.feat_vec_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept", int'(bus_if.feat_vec_ready), 1);
    if (bus_if.feat_vec_ready) begin
      for (int i = 0; i < NFO; i++) begin
`ifdef NEW_FEATURE_WRITER_RELU_EN
        exp_q.push_back('{exp_addr + i, tbl[idx].relu[i]});
`else
        exp_q.push_back('{exp_addr + i, tbl[idx].sat[i]});
`endif
      end
      exp_addr += NFO;
    end
    @(negedge clk);
    bus_if.feat_vec_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_q.delete();
    exp_addr = 0;
    check("start_ready", int'(bus_if.feat_vec_ready), 1);
    check("start_no_write", int'(bus_if.feat_bram_ena), 0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", int'(done), 1);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, int'(bus_if.feat_vec_ready), 0);
    check({tag, "_ena"},   int'(bus_if.feat_bram_ena), 0);
    check({tag, "_wea"},   int'(bus_if.feat_bram_wea), 0);
    check({tag, "_addra"}, int'(bus_if.feat_bram_addra), 0);
    check({tag, "_din"},   int'(bus_if.feat_bram_din), 0);
    check({tag, "_sgcnt"}, int'(subgraph_cnt), 0);
    check({tag, "_done"},  int'(done), 0);
    check({tag, "_ovf"},   int'(overflow_err), 0);
  endtask

  initial begin
    tbl[0] = '{'{300, -300, 5, -7},           '{127, -128, 5, -7},    '{127, 0, 5, 0}};
    tbl[1] = '{'{127, -128, 128, -129},       '{127, -128, 127, -128}, '{127, 0, 127, 0}};
    tbl[2] = '{'{524287, -524288, 0, -1},     '{127, -128, 0, -1},    '{127, 0, 0, 0}};
    tbl[3] = '{'{1000, -1000, 64, -100},      '{127, -128, 64, -100}, '{127, 0, 64, 0}};
    bus_if.feat_vec_valid = 1'b0;
    bus_if.feat_vec_data  = '0;

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", int'(bus_if.feat_vec_ready), 0);

    // Saturation and back-to-back run over the whole table
    pulse_start();
    for (int i = 0; i < NSG; i++) send_vec(i);
    wait_done();
    check("done_after_last_write", done_cyc, last_wr_cyc + 1);
    check("contiguous_span", last_wr_cyc - first_wr_cyc, DEPTH - 1);
    check("run_sgcnt", int'(subgraph_cnt), NSG);
    check("done_ready", int'(bus_if.feat_vec_ready), 0);
    check("run_queue_empty", exp_q.size(), 0);

    // Valid while done: not consumed, overflow sticky, cleared by start
    bus_if.feat_vec_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("ovf_ready", int'(bus_if.feat_vec_ready), 0);
      check("ovf_no_write", int'(bus_if.feat_bram_ena), 0);
    end
    check("ovf_set", int'(overflow_err), 1);
    check("ovf_done_held", int'(done), 1);
    bus_if.feat_vec_valid = 1'b0;
    pulse_start();
    check("ovf_cleared", int'(overflow_err), 0);
    check("done_cleared", int'(done), 0);
    check("restart_sgcnt", int'(subgraph_cnt), 0);

    // Backpressure: five idle cycles between vectors
    send_vec(3);
    repeat (3) @(negedge clk);
    for (int g = 0; g < 5; g++) begin
      @(negedge clk);
      check("gap_ready", int'(bus_if.feat_vec_ready), 1);
      check("gap_no_write", int'(bus_if.feat_bram_ena), 0);
    end
    check("gap_sgcnt", int'(subgraph_cnt), 1);
    send_vec(0);
    send_vec(1);
    wait_done();
    check("bp_queue_empty", exp_q.size(), 0);
    check("bp_sgcnt", int'(subgraph_cnt), NSG);

    // Abort during the write of address 5
    pulse_start();
    send_vec(2);
    send_vec(3);
    @(negedge clk);
    check("abort_at_addr", int'(bus_if.feat_bram_addra), 5);
    check("abort_pre_sgcnt", int'(subgraph_cnt), 1);
    pulse_start();
    check("abort_sgcnt", int'(subgraph_cnt), 0);
    send_vec(0);
    repeat (4) @(negedge clk);
    check("abort_post_sgcnt", int'(subgraph_cnt), 1);
    check("abort_queue_empty", exp_q.size(), 0);

    // Asynchronous reset in the middle of a write burst
    send_vec(1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    exp_q.delete();
    exp_addr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", int'(bus_if.feat_vec_ready), 0);
    check("post_rst_ena", int'(bus_if.feat_bram_ena), 0);
    pulse_start();
    send_vec(0);
    repeat (4) @(negedge clk);
    check("post_rst_queue_empty", exp_q.size(), 0);
    check("post_rst_sgcnt", int'(subgraph_cnt), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
